// File: rtl/quadrature_oscillator_agc_if.sv
// Control/data bundle of the quadrature oscillator: coefficients, init values, mode bits and state outputs.
// Latency: none (plain wiring bundle).
// Backpressure: none; the oscillator is free-running and the consumer samples on sample_valid.
interface quadrature_oscillator_agc_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);
  logic                    load;
  logic                    enable;
  logic                    agc_en;
  logic        [DIV_W-1:0] rate;
  logic signed [WIDTH-1:0] re_coeff;
  logic signed [WIDTH-1:0] im_coeff;
  logic signed [WIDTH-1:0] power;
  logic signed [WIDTH-1:0] accu_re_init;
  logic signed [WIDTH-1:0] accu_im_init;
  logic signed [WIDTH-1:0] accu_re;
  logic signed [WIDTH-1:0] accu_im;
  logic                    sample_valid;
  logic                    sat_flag;
  logic                    running;

  // Controller side: drives configuration, observes the oscillator state
  modport master (
    output load, enable, agc_en, rate, re_coeff, im_coeff, power, accu_re_init, accu_im_init,
    input  accu_re, accu_im, sample_valid, sat_flag, running
  );

  // Oscillator side
  modport slave (
    input  load, enable, agc_en, rate, re_coeff, im_coeff, power, accu_re_init, accu_im_init,
    output accu_re, accu_im, sample_valid, sat_flag, running
  );
endinterface

// File: rtl/quadrature_oscillator_agc.sv
// Complex rotator oscillator with optional AGC toward a target power, saturation and a sticky flag.
// Latency: state updates on the step edge; sample_valid pulses in the cycle after each step.
// Backpressure: none; enable=0 freezes state and divider, no valid pulses while frozen.
module quadrature_oscillator_agc #(
  parameter int WIDTH     = 8,
  parameter int FRAC      = WIDTH - 1,
  parameter int DIV_W     = 8,
  parameter int AGC_SHIFT = 4
) (
  input logic                       clk,
  input logic                       rst,
  quadrature_oscillator_agc_if.slave bus
);

  // Working width: wide enough that products of rotated state and error never overflow.
  localparam int XW = 4 * WIDTH + 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic signed [XW-1:0] MAXV = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] r_accu_re;
  logic signed [WIDTH-1:0] r_accu_im;
  logic                    r_valid;
  logic                    r_sat;
  logic [0:0]              r_state;
  logic [DIV_W-1:0]        r_div_cnt;

  logic                    w_step;
  logic signed [XW-1:0]    w_re, w_im, w_cre, w_cim, w_pwr;
  logic signed [XW-1:0]    w_rot_re, w_rot_im, w_mag2, w_err;
  logic signed [XW-1:0]    w_corr_re, w_corr_im, w_nxt_re, w_nxt_im;
  logic signed [WIDTH-1:0] w_sat_re, w_sat_im;
  logic                    w_clip_re, w_clip_im;

  function automatic logic signed [XW-1:0] sx(input logic signed [WIDTH-1:0] v);
    return {{(XW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  assign w_re  = sx(r_accu_re);
  assign w_im  = sx(r_accu_im);
  assign w_cre = sx(bus.re_coeff);
  assign w_cim = sx(bus.im_coeff);
  assign w_pwr = sx(bus.power);

  // A step fires when running, enabled, and the divider has reached the programmed rate.
  assign w_step = (r_state == ST_RUN) && bus.enable && (r_div_cnt >= bus.rate);

  // Full-precision rotation plus AGC correction; >>> floors because all operands are signed.
  always_comb begin
    w_rot_re  = (w_re * w_cre - w_im * w_cim) >>> FRAC;
    w_rot_im  = (w_re * w_cim + w_im * w_cre) >>> FRAC;
    w_mag2    = (w_re * w_re + w_im * w_im) >>> FRAC;
    w_err     = w_pwr - w_mag2;
    w_corr_re = '0;
    w_corr_im = '0;
    if (bus.agc_en) begin
      w_corr_re = (w_rot_re * w_err) >>> (FRAC + AGC_SHIFT);
      w_corr_im = (w_rot_im * w_err) >>> (FRAC + AGC_SHIFT);
    end
    w_nxt_re = w_rot_re + w_corr_re;
    w_nxt_im = w_rot_im + w_corr_im;
  end

  // Clamp each component to the signed WIDTH range and report any clipping.
  always_comb begin
    w_clip_re = 1'b1;
    w_clip_im = 1'b1;
    if (w_nxt_re > MAXV)      w_sat_re = MAXV[WIDTH-1:0];
    else if (w_nxt_re < MINV) w_sat_re = MINV[WIDTH-1:0];
    else begin
      w_sat_re  = w_nxt_re[WIDTH-1:0];
      w_clip_re = 1'b0;
    end
    if (w_nxt_im > MAXV)      w_sat_im = MAXV[WIDTH-1:0];
    else if (w_nxt_im < MINV) w_sat_im = MINV[WIDTH-1:0];
    else begin
      w_sat_im  = w_nxt_im[WIDTH-1:0];
      w_clip_im = 1'b0;
    end
  end

  // State, divider and flags: reset beats load, load beats step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accu_re <= '0;
      r_accu_im <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
    end else if (bus.load) begin
      r_accu_re <= bus.accu_re_init;
      r_accu_im <= bus.accu_im_init;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_state   <= ST_RUN;
      r_div_cnt <= '0;
    end else if (w_step) begin
      r_accu_re <= w_sat_re;
      r_accu_im <= w_sat_im;
      r_valid   <= 1'b1;
      r_sat     <= r_sat | w_clip_re | w_clip_im;
      r_div_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state == ST_RUN) && bus.enable) r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign bus.accu_re      = r_accu_re;
  assign bus.accu_im      = r_accu_im;
  assign bus.sample_valid = r_valid;
  assign bus.sat_flag     = r_sat;
  assign bus.running      = (r_state == ST_RUN);

endmodule
